// File: rtl/ahb_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_mem_slave
// Brief    : AHB-Lite word memory responder with byte lanes, wait states and
//            two-cycle ERROR response for illegal transfers.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_mem_slave #(
    parameter int ADDR_W      = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         c_depth = 2 ** ADDR_W;
    localparam logic [2:0] c_ws    = 3'(WAIT_STATES);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_data = 2'd1;
    localparam logic [1:0] c_err1 = 2'd2;
    localparam logic [1:0] c_err2 = 2'd3;

    logic [1:0]        r_state, w_next_state;
    logic [2:0]        r_cnt, w_next_cnt;
    logic [ADDR_W-1:0] r_idx;
    logic [1:0]        r_lo;
    logic [1:0]        r_size;
    logic              r_write;
    logic [31:0]       r_mem [c_depth];

    logic              w_final, w_open, w_accept, w_hi_bad, w_illegal;
    logic [3:0]        w_lane_en;
    logic              w_unused;

    assign w_unused = &{1'b0, HADDR[31:16], HTRANS[0]};

    // A new address phase may only land when the current data phase completes.
    assign w_final  = (r_state == c_data) && (r_cnt == 3'd0);
    assign w_open   = (r_state == c_idle) || w_final || (r_state == c_err2);
    assign w_accept = w_open && HSEL && HREADY && HTRANS[1];

    assign w_hi_bad  = |(HADDR[15:0] >> (ADDR_W + 2));
    assign w_illegal = (HSIZE > 3'd2)
                    || ((HSIZE == 3'd1) && HADDR[0])
                    || ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
                    || w_hi_bad;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            c_data:  if (r_cnt != 3'd0) w_next_cnt = r_cnt - 3'd1;
            c_err1:  w_next_state = c_err2;
            default: ;
        endcase
        if (w_open) begin
            if (w_accept && w_illegal) begin
                w_next_state = c_err1;
                w_next_cnt   = 3'd0;
            end else if (w_accept) begin
                w_next_state = c_data;
                w_next_cnt   = c_ws;
            end else begin
                w_next_state = c_idle;
                w_next_cnt   = 3'd0;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= c_idle;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_idx   <= '0;
            r_lo    <= 2'b00;
            r_size  <= 2'b00;
            r_write <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= HADDR[ADDR_W+1:2];
            r_lo    <= HADDR[1:0];
            r_size  <= HSIZE[1:0];
            r_write <= HWRITE;
        end
    end

    always_comb begin
        w_lane_en = 4'b1111;
        case (r_size)
            2'd0:    w_lane_en = 4'b0001 << r_lo;
            2'd1:    w_lane_en = r_lo[1] ? 4'b1100 : 4'b0011;
            default: w_lane_en = 4'b1111;
        endcase
    end

    // Commit on the edge closing the final data cycle, so a pipelined read
    // of the same word already sees the new contents.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
        end else if (w_final && r_write) begin
            for (int l = 0; l < 4; l++) begin
                if (w_lane_en[l]) r_mem[r_idx][8*l +: 8] <= HWDATA[8*l +: 8];
            end
        end
    end

    assign HREADYOUT = w_open;
    assign HRESP     = (r_state == c_err1) || (r_state == c_err2);
    assign HRDATA    = (w_final && !r_write) ? r_mem[r_idx] : 32'h0;

endmodule
`default_nettype wire
